mult_datapath: RTL and testbench

//  Datapath stage driven by the shift-and-add multiplier controller FSM.
//  - Consumes the controller's 16-bit control word each cycle; holds operands/accumulator in a register file.
//  - Executes one ALU op per cycle; returns registered status flags (mayor, paridad, compuor) to the FSM.
//  - Exposes the accumulator as the multiply result; accepts new operands through a load strobe.

---
 rtl/mult_datapath_pkg.sv | 45 ++++
 rtl/mult_datapath_if.sv | 23 ++
 rtl/mult_datapath_alu.sv | 34 +++
 rtl/mult_datapath.sv | 77 +++++++
 tb/tb_mult_datapath.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mult_datapath_pkg.sv
// Shared definitions for the shift-and-add multiplier: control-word layout, ALU opcodes
// and the default accumulator index. The controller FSM imports the same package.
package mult_datapath_pkg;

  localparam int CTRL_W      = 16;
  localparam int ALU_OP_LSB  = 13;
  localparam int ALU_OP_W    = 3;
  localparam int SEL_A_LSB   = 9;
  localparam int SEL_B_LSB   = 5;
  localparam int SEL_REG_LSB = 1;
  localparam int SEL_W       = 4;
  localparam int W_BIT       = 0;

  localparam int ACC_IDX_DEF = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SHL  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_SHR  = 3'b011,
    ALU_PASS = 3'b100,
    ALU_AND  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_XOR  = 3'b111
  } alu_op_t;

  typedef struct packed {
    alu_op_t          alu_op;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] sel_reg;
    logic             w;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [CTRL_W-1:0] word);
    ctrl_t c;
    c.alu_op  = alu_op_t'(word[ALU_OP_LSB +: ALU_OP_W]);
    c.sel_a   = word[SEL_A_LSB +: SEL_W];
    c.sel_b   = word[SEL_B_LSB +: SEL_W];
    c.sel_reg = word[SEL_REG_LSB +: SEL_W];
    c.w       = word[W_BIT];
    return c;
  endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// Controller-to-datapath bus: control word, operand load and the status/result returned.
interface mult_datapath_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      i_signal;
  logic             i_load;
  logic [WIDTH-1:0] i_op_a;
  logic [WIDTH-1:0] i_op_b;
  logic [WIDTH-1:0] o_result;
  logic             o_mayor;
  logic             o_paridad;
  logic             o_compuor;

  modport master (
    output i_signal, i_load, i_op_a, i_op_b,
    input  o_result, o_mayor, o_paridad, o_compuor
  );

  modport slave (
    input  i_signal, i_load, i_op_a, i_op_b,
    output o_result, o_mayor, o_paridad, o_compuor
  );
endinterface

// File: rtl/mult_datapath_alu.sv
// Combinational ALU for the multiplier datapath; all results wrap modulo 2^WIDTH.
module mult_datapath_alu
  import mult_datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             gt,
  output logic             zero
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SHL:  result = {a[WIDTH-2:0], 1'b0};
      ALU_SUB:  result = a - b;
      ALU_SHR:  result = {1'b0, a[WIDTH-1:1]};
      ALU_PASS: result = a;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      default:  result = '0;
    endcase
  end

  // Comparison is on raw operands, not on the op result, so it is valid for any opcode.
  assign gt   = (a > b);
  assign zero = (result == '0);

endmodule

// File: rtl/mult_datapath.sv
// Multiplier datapath: register file, operand mux, ALU and registered status flags
// feeding the controller FSM. The accumulator register is exposed directly as the result.
module mult_datapath
  import mult_datapath_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NREG    = 16,
  parameter int ACC_IDX = ACC_IDX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mult_datapath_if.slave  bus
);

  logic [WIDTH-1:0] regs [NREG];

  ctrl_t            ctrl_p0;
  logic [WIDTH-1:0] opa_p0;
  logic [WIDTH-1:0] opb_p0;
  logic [WIDTH-1:0] alu_res_p0;
  logic             alu_gt_p0;
  logic             alu_zero_p0;

  logic             mayor_p1;
  logic             paridad_p1;
  logic             compuor_p1;

  // Stage p0: decode, unbypassed register read, ALU
  assign ctrl_p0 = decode_ctrl(bus.i_signal);
  assign opa_p0  = regs[ctrl_p0.sel_a];
  assign opb_p0  = regs[ctrl_p0.sel_b];

  mult_datapath_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (opa_p0),
    .b      (opb_p0),
    .op     (ctrl_p0.alu_op),
    .result (alu_res_p0),
    .gt     (alu_gt_p0),
    .zero   (alu_zero_p0)
  );

  // Load has priority: a control write in the same cycle is discarded whatever its target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.i_load) begin
      regs[0]       <= bus.i_op_a;
      regs[1]       <= bus.i_op_b;
      regs[ACC_IDX] <= '0;
    end else if (ctrl_p0.w) begin
      regs[ctrl_p0.sel_reg] <= alu_res_p0;
    end
  end

  // Stage p1: flags sampled every cycle, regardless of write enable or load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mayor_p1   <= 1'b0;
      paridad_p1 <= 1'b0;
      compuor_p1 <= 1'b0;
    end else begin
      mayor_p1   <= alu_gt_p0;
      paridad_p1 <= alu_res_p0[0];
      compuor_p1 <= alu_zero_p0;
    end
  end

  assign bus.o_result  = regs[ACC_IDX];
  assign bus.o_mayor   = mayor_p1;
  assign bus.o_paridad = paridad_p1;
  assign bus.o_compuor = compuor_p1;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed testbench for mult_datapath with hand-computed expected values.
module tb_mult_datapath;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;

  mult_datapath_if #(.WIDTH(WIDTH)) bus ();

  mult_datapath #(
    .WIDTH   (WIDTH),
    .NREG    (16),
    .ACC_IDX (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cw(input logic [2:0] op, input logic [3:0] sa,
                                     input logic [3:0] sb, input logic [3:0] sr, input logic w);
    return {op, sa, sb, sr, w};
  endfunction

  // Advance one clock; return 1 time unit after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] b);
    bus.i_load   = 1'b1;
    bus.i_op_a   = a;
    bus.i_op_b   = b;
    bus.i_signal = 16'h0000;
    tick();
    bus.i_load   = 1'b0;
  endtask

  task automatic apply(input logic [15:0] word);
    bus.i_signal = word;
    tick();
    bus.i_signal = 16'h0000;
  endtask

  logic [15:0] exp_tbl [8];

  initial begin
    exp_tbl = '{16'hD34A, 16'h86B4, 16'hB36A, 16'h61AD,
                16'hC35A, 16'h0350, 16'hCFFA, 16'hCCAA};

    rst          = 1'b0;
    bus.i_signal = 16'h0000;
    bus.i_load   = 1'b0;
    bus.i_op_a   = '0;
    bus.i_op_b   = '0;

    // Reset held with random control activity
    for (int i = 0; i < 4; i++) begin
      bus.i_signal = 16'($urandom);
      bus.i_load   = 1'($urandom);
      bus.i_op_a   = 16'($urandom);
      bus.i_op_b   = 16'($urandom);
      tick();
      check_eq("rst_result", bus.o_result, 16'h0000);
      check_eq("rst_flags", {bus.o_mayor, bus.o_paridad, bus.o_compuor}, 3'b000);
    end
    bus.i_signal = 16'h0000;
    bus.i_load   = 1'b0;
    rst          = 1'b1;

    apply(cw(3'b100, 4'd3, 4'd0, 4'd0, 1'b0));
    check_eq("rst_reg3_zero", bus.o_compuor, 1'b1);
    apply(cw(3'b100, 4'd12, 4'd0, 4'd5, 1'b1));
    check_eq("rst_reg12_copy", bus.o_result, 16'h0000);

    // Load then parity
    do_load(16'd6, 16'd7);
    apply(16'h8000);
    check_eq("par_even", bus.o_paridad, 1'b0);
    check_eq("par_even_z", bus.o_compuor, 1'b0);
    do_load(16'd5, 16'd7);
    apply(16'h8000);
    check_eq("par_odd", bus.o_paridad, 1'b1);

    // Add with write-back into the accumulator
    do_load(16'd3, 16'd7);
    apply(cw(3'b100, 4'd0, 4'd0, 4'd5, 1'b1));
    check_eq("acc_init", bus.o_result, 16'd3);
    apply(16'h02AB);
    check_eq("add_result", bus.o_result, 16'd10);
    check_eq("add_mayor", bus.o_mayor, 1'b1);
    apply(16'h0000);
    check_eq("nop_result", bus.o_result, 16'd10);
    check_eq("nop_flags", {bus.o_paridad, bus.o_compuor}, 2'b00);

    do_load(16'hFFFF, 16'h0001);
    apply(cw(3'b000, 4'd0, 4'd1, 4'd5, 1'b1));
    check_eq("add_wrap", bus.o_result, 16'h0000);
    check_eq("add_wrap_z", bus.o_compuor, 1'b1);

    // Shifts, including in-place read-modify-write
    do_load(16'h8000, 16'd7);
    apply(16'h6203);
    apply(cw(3'b100, 4'd1, 4'd0, 4'd5, 1'b1));
    check_eq("shr_reg1", bus.o_result, 16'd3);
    apply(16'h2001);
    apply(cw(3'b100, 4'd0, 4'd0, 4'd6, 1'b1));
    check_eq("shl_out_z", bus.o_compuor, 1'b1);
    apply(cw(3'b100, 4'd2, 4'd0, 4'd0, 1'b0));
    check_eq("pass_nz_z", bus.o_compuor, 1'b1);
    do_load(16'h0004, 16'h0000);
    apply(16'h8000);
    check_eq("pass_nz", bus.o_compuor, 1'b0);

    do_load(16'd2, 16'd5);
    apply(cw(3'b010, 4'd0, 4'd1, 4'd5, 1'b1));
    check_eq("sub_wrap", bus.o_result, 16'hFFFD);

    // All opcodes over one operand pair
    do_load(16'hC35A, 16'h0FF0);
    for (int op = 0; op < 8; op++) begin
      apply(cw(3'(op), 4'd0, 4'd1, 4'd5, 1'b1));
      check_eq($sformatf("op%0d_res", op), bus.o_result, exp_tbl[op]);
      check_eq($sformatf("op%0d_par", op), bus.o_paridad, exp_tbl[op][0]);
      check_eq($sformatf("op%0d_gt", op), bus.o_mayor, 1'b1);
    end

    // Load and control write in the same cycle
    bus.i_load   = 1'b1;
    bus.i_op_a   = 16'd9;
    bus.i_op_b   = 16'd4;
    bus.i_signal = 16'h02AB;
    tick();
    bus.i_load   = 1'b0;
    bus.i_signal = 16'h0000;
    check_eq("sim_acc", bus.o_result, 16'h0000);
    apply(cw(3'b100, 4'd0, 4'd0, 4'd5, 1'b1));
    check_eq("sim_reg0", bus.o_result, 16'd9);
    apply(cw(3'b100, 4'd1, 4'd0, 4'd5, 1'b1));
    check_eq("sim_reg1", bus.o_result, 16'd4);
    bus.i_load   = 1'b1;
    bus.i_op_a   = 16'd1;
    bus.i_op_b   = 16'd2;
    bus.i_signal = cw(3'b100, 4'd0, 4'd0, 4'd7, 1'b1);
    tick();
    bus.i_load   = 1'b0;
    apply(cw(3'b100, 4'd7, 4'd0, 4'd5, 1'b1));
    check_eq("sim_drop_r7", bus.o_result, 16'h0000);

    // Compare and asynchronous reset mid-sequence
    do_load(16'd2, 16'd3);
    apply(cw(3'b100, 4'd0, 4'd1, 4'd0, 1'b0));
    check_eq("cmp_lt", bus.o_mayor, 1'b0);
    do_load(16'd3, 16'd2);
    apply(cw(3'b100, 4'd0, 4'd1, 4'd5, 1'b1));
    check_eq("cmp_gt", bus.o_mayor, 1'b1);
    check_eq("cmp_acc", bus.o_result, 16'd3);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_result", bus.o_result, 16'h0000);
    check_eq("arst_flags", {bus.o_mayor, bus.o_paridad, bus.o_compuor}, 3'b000);
    bus.i_signal = cw(3'b100, 4'd0, 4'd1, 4'd5, 1'b1);
    tick();
    check_eq("arst_hold", bus.o_result, 16'h0000);
    rst = 1'b1;
    apply(cw(3'b100, 4'd0, 4'd0, 4'd0, 1'b0));
    check_eq("arst_reg0", bus.o_compuor, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
